wb_arb2: RTL and testbench
==========================

# wb_arb2

Two-master to one-slave arbiter for the pipelined Wishbone bus. It sits directly downstream of the two core-to-Wishbone converters (Ibex instruction port and data port) and upstream of the shared slave interconnect. It grants one master at a time with round-robin fairness and locks the grant for the master's whole bus cycle. It also limits outstanding pipelined requests and routes ack/err only to the current owner.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; SEL_W = DATA_W/8
- MAX_OUTST, 4, maximum accepted-but-unacknowledged requests (1..15)

Ports. Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst, as the codebase does.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write
- m0_adr_i  in  ADDR_W  master 0 address
- m0_sel_i  in  SEL_W  master 0 byte selects
- m0_dat_i  in  DATA_W  master 0 write data
- m0_ack_o, m0_err_o, m0_stall_o  out  1 each  master 0 responses
- m0_dat_o  out  DATA_W  master 0 read data
- m1_*  same set as m0_*  master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write
- s_adr_o  out  ADDR_W; s_sel_o  out  SEL_W; s_dat_o  out  DATA_W
- s_ack_i, s_err_i, s_stall_i  in  1 each  slave responses
- s_dat_i  in  DATA_W  slave read data

## Operation
- State register: IDLE, OWN0, OWN1. Also a last-grant bit `lg` and an outstanding counter `cnt` of width $clog2(MAX_OUTST+1).
- Arbitration function `arb`:
  - picks the only requester (mX_cyc_i=1);
  - if both request, picks the master not equal to `lg`;
  - if none request, returns IDLE.
- IDLE: next state = arb. `lg` updates to the chosen master.
- OWNx with mX_cyc_i=1: stay in OWNx.
- OWNx with mX_cyc_i=0: the cycle is ended or aborted. Next state = arb (a direct OWN0 to OWN1 hand-over is allowed); `cnt` clears to 0.
- Forwarding (combinational from state):
  - In OWNx: s_cyc_o = mX_cyc_i; s_stb_o = mX_stb_i & (cnt < MAX_OUTST); we/adr/sel/dat are driven from master X.
  - In IDLE: all s_* outputs are 0.
- Stall:
  - mX_stall_o = 1 unless state is OWNx.
  - In OWNx: mX_stall_o = s_stall_i | (cnt == MAX_OUTST).
- Responses:
  - mX_ack_o = s_ack_i & (state==OWNx) & (cnt != 0); mX_err_o is formed the same way with s_err_i.
  - An ack/err arriving with cnt==0 or in IDLE is spurious; it is dropped and cnt is unchanged.
- m0_dat_o = m1_dat_o = s_dat_i, broadcast. Only ack qualifies the data.
- Counter:
  - increments on accept (s_stb_o & ~s_stall_i);
  - decrements on a forwarded ack|err;
  - is unchanged when both happen in the same cycle;
  - never exceeds MAX_OUTST and never underflows.

## Timing
- Reset values: state IDLE, `lg`=1 (so m0 wins the first tie), cnt=0. This gives s_cyc_o=s_stb_o=s_we_o=0, s_adr_o/s_sel_o/s_dat_o=0, m*_ack_o=m*_err_o=0, m*_stall_o=1.
- Grant latency is 1 cycle:
  - mX_cyc_i/stb_i rise in cycle N; the state is OWNx in N+1.
  - s_stb_o is visible in N+1 and the request is accepted there if s_stall_i=0.
  - mX_stall_o is 1 in cycle N, so the master holds its request.
- Release: owner cyc drops in cycle N; s_cyc_o is 0 in N (combinational follow). The other waiting master owns the bus in N+1.
- Ack to master is 0-cycle combinational from s_ack_i.
- Reset asserted mid-cycle: the next edge returns to the reset values, including cnt=0. Acks still in flight after reset are dropped as spurious.
- Grant is held while cyc stays high, even with stb low; there is no preemption.

## Test plan
- Single master: m0 does 3 pipelined reads, slave acks 2 cycles after each accept. Required: s_stb_o first seen one cycle after m0 request; m0 gets 3 acks with matching data; m1_ack_o stays 0.
- Simultaneous request after reset: m0 and m1 raise cyc in the same cycle. Required: m0 is granted first. m1 is granted the cycle after m0 drops cyc, then m0 is granted next when both re-request.
- Outstanding limit: MAX_OUTST=4, slave never acks, m1 streams 6 writes. Required: exactly 4 accepts, then m1_stall_o=1 and s_stb_o=0. One ack brings cnt to 3 and allows exactly one more accept.
- Same-cycle accept and ack at cnt=2: required cnt remains 2.
- Abort: m0 drops cyc with cnt=2. Required: cnt=0 next cycle, a waiting m1 is granted, and a late s_ack_i arriving before m1's first accept reaches neither master.
- Reset mid-transfer: rst is pulsed while in OWN1 with cnt=3. Required: all outputs are at reset values the next cycle, and the state is IDLE.

Source files
------------

// File: rtl/wb_arb2.sv
// wb_arb2 -- two-master to one-slave arbiter for pipelined Wishbone.
//
// Grants one master at a time with round-robin fairness and holds the grant
// for the whole bus cycle (while the owner keeps cyc high). It caps the number
// of accepted-but-unacknowledged requests at MAX_OUTST. It routes ack/err
// only to the current owner. Read data is broadcast to both masters, and the
// owner's ack qualifies it.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   m0_* / m1_*                 master-side Wishbone (cyc/stb/we/adr/sel/dat in,
//                               ack/err/stall/dat out)
//   s_*                         slave-side Wishbone (cyc/stb/we/adr/sel/dat out,
//                               ack/err/stall/dat in)
module wb_arb2 #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  localparam int SEL_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_stall_o,
  output logic [DATA_W-1:0] m0_dat_o,
  // master 1
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_stall_o,
  output logic [DATA_W-1:0] m1_dat_o,
  // slave
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_stall_i,
  input  logic [DATA_W-1:0] s_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e           state_q, state_d;
  logic             lg_q, lg_d;        // last granted master
  logic [CNT_W-1:0] cnt_q, cnt_d;      // outstanding requests of the owner

  logic   own0_s, own1_s;
  logic   cnt_full_s, cnt_zero_s;
  logic   accept_s, fwd_resp_s;
  logic   rearb_s;
  state_e arb_s;

  // Round-robin pick: a lone requester wins, and on a tie the master that
  // was not granted last wins.
  function automatic state_e arb(input logic cyc0, input logic cyc1, input logic last);
    state_e res;
    if (cyc0 && cyc1) begin
      res = last ? OWN0 : OWN1;
    end else if (cyc0) begin
      res = OWN0;
    end else if (cyc1) begin
      res = OWN1;
    end else begin
      res = IDLE;
    end
    return res;
  endfunction

  assign own0_s     = (state_q == OWN0);
  assign own1_s     = (state_q == OWN1);
  assign cnt_full_s = (cnt_q == CNT_MAX);
  assign cnt_zero_s = (cnt_q == CNT_ZERO);
  assign arb_s      = arb(m0_cyc_i, m1_cyc_i, lg_q);

  // A response arriving with nothing outstanding (or with no owner) is
  // spurious, typically a leftover from an aborted cycle, and is dropped.
  assign fwd_resp_s = (s_ack_i | s_err_i) & (own0_s | own1_s) & ~cnt_zero_s;
  assign accept_s   = s_stb_o & ~s_stall_i;

  assign m0_ack_o   = s_ack_i & own0_s & ~cnt_zero_s;
  assign m0_err_o   = s_err_i & own0_s & ~cnt_zero_s;
  assign m1_ack_o   = s_ack_i & own1_s & ~cnt_zero_s;
  assign m1_err_o   = s_err_i & own1_s & ~cnt_zero_s;

  assign m0_stall_o = own0_s ? (s_stall_i | cnt_full_s) : 1'b1;
  assign m1_stall_o = own1_s ? (s_stall_i | cnt_full_s) : 1'b1;

  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;

  // Forward the owner's request signals to the slave; the strobe is masked
  // once the outstanding limit is reached.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = {ADDR_W{1'b0}};
    s_sel_o = {SEL_W{1'b0}};
    s_dat_o = {DATA_W{1'b0}};
    case (state_q)
      OWN0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~cnt_full_s;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
      end
      OWN1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~cnt_full_s;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  // Next state, last-grant and outstanding-counter logic.
  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    cnt_d   = cnt_q;
    rearb_s = 1'b0;
    case (state_q)
      IDLE: begin
        rearb_s = 1'b1;
      end
      OWN0: begin
        rearb_s = ~m0_cyc_i;
      end
      OWN1: begin
        rearb_s = ~m1_cyc_i;
      end
      default: begin
        rearb_s = 1'b1;
      end
    endcase

    if (rearb_s) begin
      // Owner ended or aborted its cycle (or nobody owned the bus): hand over
      // directly, forgetting whatever the old owner still had outstanding.
      state_d = arb_s;
      cnt_d   = CNT_ZERO;
      if (arb_s != IDLE) begin
        lg_d = (arb_s == OWN1);
      end else begin
        lg_d = lg_q;
      end
    end else if (accept_s && !fwd_resp_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!accept_s && fwd_resp_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset; lg resets to 1 so m0 wins the
  // first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lg_q    <= 1'b1;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Testbench for wb_arb2: a table of per-cycle vectors followed by a short
// hand-written grant/hand-over sequence.
module tb_wb_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o, m0_stall_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o, m1_stall_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_stall_i;
  logic [31:0] s_dat_i;

  int checks = 0;
  int errors = 0;

  wb_arb2 #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i)
  );

  always #5 clk = ~clk;

  // in  = {rst, m0 cyc stb we, m1 cyc stb we, s ack err stall}
  // so  = {s_cyc_o, s_stb_o, s_we_o}
  // own = whose adr/sel/dat appear on the slave side (0 none, 1 m0, 2 m1)
  // mo  = {m0 ack err stall, m1 ack err stall}
  typedef struct {
    logic [9:0] in;
    logic [2:0] so;
    logic [1:0] own;
    logic [5:0] mo;
  } vec_t;

  localparam int NV = 49;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // reset state and spurious ack in IDLE
    tbl[0]  = '{10'b0_000_000_000, 3'b000, 2'd0, 6'b001_001};
    tbl[1]  = '{10'b0_000_000_100, 3'b000, 2'd0, 6'b001_001};
    // single master: m0 three pipelined reads, ack 2 cycles after accept
    tbl[2]  = '{10'b0_110_000_000, 3'b000, 2'd0, 6'b001_001};
    tbl[3]  = '{10'b0_110_000_000, 3'b110, 2'd1, 6'b000_001};
    tbl[4]  = '{10'b0_110_000_000, 3'b110, 2'd1, 6'b000_001};
    tbl[5]  = '{10'b0_110_000_100, 3'b110, 2'd1, 6'b100_001};
    tbl[6]  = '{10'b0_100_000_100, 3'b100, 2'd1, 6'b100_001};
    tbl[7]  = '{10'b0_100_000_100, 3'b100, 2'd1, 6'b100_001};
    tbl[8]  = '{10'b0_000_000_000, 3'b000, 2'd1, 6'b000_001};
    // reset, then simultaneous request: m0 first, m1 after m0 drops, m0 again
    tbl[9]  = '{10'b1_000_000_000, 3'b000, 2'd0, 6'b001_001};
    tbl[10] = '{10'b0_100_100_000, 3'b000, 2'd0, 6'b001_001};
    tbl[11] = '{10'b0_100_100_000, 3'b100, 2'd1, 6'b000_001};
    tbl[12] = '{10'b0_000_100_000, 3'b000, 2'd1, 6'b000_001};
    tbl[13] = '{10'b0_000_101_000, 3'b101, 2'd2, 6'b001_000};
    tbl[14] = '{10'b0_000_001_000, 3'b001, 2'd2, 6'b001_000};
    tbl[15] = '{10'b0_100_100_000, 3'b000, 2'd0, 6'b001_001};
    tbl[16] = '{10'b0_100_100_000, 3'b100, 2'd1, 6'b000_001};
    tbl[17] = '{10'b0_000_100_000, 3'b000, 2'd1, 6'b000_001};
    // outstanding limit: m1 streams writes, no acks
    tbl[18] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[19] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[20] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[21] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[22] = '{10'b0_000_111_000, 3'b101, 2'd2, 6'b001_001};
    tbl[23] = '{10'b0_000_111_000, 3'b101, 2'd2, 6'b001_001};
    tbl[24] = '{10'b0_000_111_100, 3'b101, 2'd2, 6'b001_101};
    tbl[25] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[26] = '{10'b0_000_111_000, 3'b101, 2'd2, 6'b001_001};
    tbl[27] = '{10'b0_000_101_100, 3'b101, 2'd2, 6'b001_101};
    tbl[28] = '{10'b0_000_101_100, 3'b101, 2'd2, 6'b001_100};
    // accept and ack together at cnt=2, then exactly two more accepts fit
    tbl[29] = '{10'b0_000_111_100, 3'b111, 2'd2, 6'b001_100};
    tbl[30] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[31] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[32] = '{10'b0_000_111_000, 3'b101, 2'd2, 6'b001_001};
    tbl[33] = '{10'b0_000_101_100, 3'b101, 2'd2, 6'b001_101};
    // reset in OWN1 with cnt=3; in-flight acks afterwards are dropped
    tbl[34] = '{10'b1_000_101_000, 3'b101, 2'd2, 6'b001_000};
    tbl[35] = '{10'b0_000_111_100, 3'b000, 2'd0, 6'b001_001};
    tbl[36] = '{10'b0_000_111_101, 3'b111, 2'd2, 6'b001_001};
    tbl[37] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[38] = '{10'b0_000_001_000, 3'b001, 2'd2, 6'b001_000};
    // abort: m0 drops cyc at cnt=2 while m1 waits; late ack/err go nowhere
    tbl[39] = '{10'b0_110_000_000, 3'b000, 2'd0, 6'b001_001};
    tbl[40] = '{10'b0_110_111_000, 3'b110, 2'd1, 6'b000_001};
    tbl[41] = '{10'b0_110_111_000, 3'b110, 2'd1, 6'b000_001};
    tbl[42] = '{10'b0_000_111_000, 3'b000, 2'd1, 6'b000_001};
    tbl[43] = '{10'b0_000_111_101, 3'b111, 2'd2, 6'b001_001};
    tbl[44] = '{10'b0_000_111_011, 3'b111, 2'd2, 6'b001_001};
    tbl[45] = '{10'b0_000_111_000, 3'b111, 2'd2, 6'b001_000};
    tbl[46] = '{10'b0_000_101_010, 3'b101, 2'd2, 6'b001_010};
    tbl[47] = '{10'b0_000_001_000, 3'b001, 2'd2, 6'b001_000};
    tbl[48] = '{10'b0_000_000_000, 3'b000, 2'd0, 6'b001_001};

    rst = 1'b1;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = 6'b0;
    {s_ack_i, s_err_i, s_stall_i} = 3'b0;
    m0_adr_i = 32'h0; m0_dat_i = 32'h0; m0_sel_i = 4'h3;
    m1_adr_i = 32'h0; m1_dat_i = 32'h0; m1_sel_i = 4'hC;
    s_dat_i  = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      logic [31:0] e_adr, e_dat;
      logic [3:0]  e_sel;
      @(negedge clk);
      {rst, m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i,
       s_ack_i, s_err_i, s_stall_i} = tbl[i].in;
      m0_adr_i = 32'hA000_0000 + 32'(i);
      m1_adr_i = 32'hB000_0000 + 32'(i);
      m0_dat_i = 32'h0000_1000 + 32'(i);
      m1_dat_i = 32'h0000_2000 + 32'(i);
      s_dat_i  = 32'hD0D0_0000 + 32'(i);
      case (tbl[i].own)
        2'd1:    begin e_adr = 32'hA000_0000 + 32'(i); e_dat = 32'h0000_1000 + 32'(i); e_sel = 4'h3; end
        2'd2:    begin e_adr = 32'hB000_0000 + 32'(i); e_dat = 32'h0000_2000 + 32'(i); e_sel = 4'hC; end
        default: begin e_adr = 32'h0; e_dat = 32'h0; e_sel = 4'h0; end
      endcase
      #1;
      chk($sformatf("v%0d s_cyc", i),    32'(s_cyc_o),    32'(tbl[i].so[2]));
      chk($sformatf("v%0d s_stb", i),    32'(s_stb_o),    32'(tbl[i].so[1]));
      chk($sformatf("v%0d s_we", i),     32'(s_we_o),     32'(tbl[i].so[0]));
      chk($sformatf("v%0d s_adr", i),    s_adr_o,         e_adr);
      chk($sformatf("v%0d s_sel", i),    32'(s_sel_o),    32'(e_sel));
      chk($sformatf("v%0d s_dat", i),    s_dat_o,         e_dat);
      chk($sformatf("v%0d m0_ack", i),   32'(m0_ack_o),   32'(tbl[i].mo[5]));
      chk($sformatf("v%0d m0_err", i),   32'(m0_err_o),   32'(tbl[i].mo[4]));
      chk($sformatf("v%0d m0_stall", i), 32'(m0_stall_o), 32'(tbl[i].mo[3]));
      chk($sformatf("v%0d m1_ack", i),   32'(m1_ack_o),   32'(tbl[i].mo[2]));
      chk($sformatf("v%0d m1_err", i),   32'(m1_err_o),   32'(tbl[i].mo[1]));
      chk($sformatf("v%0d m1_stall", i), 32'(m1_stall_o), 32'(tbl[i].mo[0]));
      chk($sformatf("v%0d m0_dat", i),   m0_dat_o,        32'hD0D0_0000 + 32'(i));
      chk($sformatf("v%0d m1_dat", i),   m1_dat_o,        32'hD0D0_0000 + 32'(i));
    end

    // Hand-written: grant latency, direct hand-over to a waiting master,
    // and a stale response after hand-over.
    begin
      int lat;
      @(negedge clk);
      {s_ack_i, s_err_i, s_stall_i} = 3'b000;
      {m0_cyc_i, m0_stb_i, m0_we_i} = 3'b000;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
      m1_adr_i = 32'hB5B5_0000;
      m0_adr_i = 32'hA5A5_0000;
      lat = 0;
      #1;
      while (s_stb_o !== 1'b1 && lat < 8) begin
        @(negedge clk);
        #1;
        lat++;
      end
      chk("grant_latency", 32'(lat), 32'd1);
      chk("grant_adr", s_adr_o, 32'hB5B5_0000);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      #1;
      chk("waiting_m0_stall", 32'(m0_stall_o), 32'd1);

      @(negedge clk);
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      #1;
      chk("release_s_cyc", 32'(s_cyc_o), 32'd0);
      chk("release_m0_stall", 32'(m0_stall_o), 32'd1);

      @(negedge clk);
      #1;
      chk("handover_adr", s_adr_o, 32'hA5A5_0000);
      chk("handover_stb", 32'(s_stb_o), 32'd1);
      chk("handover_m0_stall", 32'(m0_stall_o), 32'd0);
      s_ack_i = 1'b1;
      #1;
      chk("stale_ack_m0", 32'(m0_ack_o), 32'd0);
      chk("stale_ack_m1", 32'(m1_ack_o), 32'd0);

      @(negedge clk);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      #1;
      chk("owner_ack_m0", 32'(m0_ack_o), 32'd1);
      chk("owner_ack_m1", 32'(m1_ack_o), 32'd0);

      @(negedge clk);
      s_ack_i = 1'b0;
      #1;
      chk("idle_m0_stall", 32'(m0_stall_o), 32'd1);
      chk("idle_m1_stall", 32'(m1_stall_o), 32'd1);
      chk("idle_s_cyc", 32'(s_cyc_o), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
